// File: rtl/combo_detector_pkg.sv
// Shared definitions for the combo detector and its consumers.
// The attack_state encoding is shared with the projectile logic.
package combo_detector_pkg;

  typedef enum logic [1:0] {
    ATK_NONE    = 2'b00,
    ATK_BASIC   = 2'b01,
    ATK_SPECIAL = 2'b11
  } attack_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BASIC,
    ST_SPECIAL,
    ST_COOLDOWN
  } state_e;

  typedef enum logic [1:0] {
    DIR_U,
    DIR_D,
    DIR_L,
    DIR_R
  } dir_e;

  localparam logic [2:0] COMBO_LAST_STEP = 3'd5;

  function automatic int unsigned cnt_width(input int unsigned a,
                                            input int unsigned b,
                                            input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    m = (m > c) ? m : c;
    return $clog2(m) + 1;
  endfunction

  // Expected direction for the press that advances combo_step past 'step'.
  function automatic dir_e combo_dir(input logic [2:0] step);
    case (step)
      3'd0:    return DIR_U;
      3'd1:    return DIR_D;
      3'd2:    return DIR_L;
      3'd3:    return DIR_R;
      3'd4:    return DIR_L;
      3'd5:    return DIR_R;
      default: return DIR_U;
    endcase
  endfunction

endpackage

// File: rtl/combo_detector_if.sv
// Player-input and attack-output bundle for combo_detector.
interface combo_detector_if;
  import combo_detector_pkg::*;

  logic       tick;
  logic       btn_u;
  logic       btn_d;
  logic       btn_l;
  logic       btn_r;
  logic       btn_c;
  logic       mirrored;
  attack_e    attack_state;
  logic [2:0] combo_step;

  modport master (
    output tick, btn_u, btn_d, btn_l, btn_r, btn_c, mirrored,
    input  attack_state, combo_step
  );

  modport slave (
    input  tick, btn_u, btn_d, btn_l, btn_r, btn_c, mirrored,
    output attack_state, combo_step
  );

endinterface

// File: rtl/combo_detector_edge_detect.sv
// Single-cycle rising-edge pulse of a synchronised level.
// Suppressed for the first cycle after reset so a held level is not seen as a press.
module edge_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic level,
  output logic rise
);

  logic prev_q, prev_d;
  logic armed_q, armed_d;

  always_comb begin
    prev_d  = level;
    armed_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q  <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      prev_q  <= prev_d;
      armed_q <= armed_d;
    end
  end

  assign rise = level & ~prev_q & armed_q;

endmodule

// File: rtl/combo_detector.sv
// Button combo matcher and attack FSM: U,D,L,R,L,R issues a special,
// btn_c issues a basic attack, with hold and cooldown timing in ticks.
module combo_detector
  import combo_detector_pkg::*;
#(
  parameter int unsigned COMBO_GAP_TICKS = 500,
  parameter int unsigned HOLD_TICKS      = 50,
  parameter int unsigned COOLDOWN_TICKS  = 1000
) (
  input  logic             clk,
  input  logic             rst_n,
  combo_detector_if.slave  bus
);

  localparam int unsigned CNT_W = cnt_width(COMBO_GAP_TICKS, HOLD_TICKS, COOLDOWN_TICKS);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(COMBO_GAP_TICKS - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_TICKS - 1);
  localparam logic [CNT_W-1:0] COOL_LAST = CNT_W'(COOLDOWN_TICKS - 1);

  logic [4:0] btn_lvl;
  logic [4:0] btn_rise;

  assign btn_lvl = {bus.btn_c, bus.btn_r, bus.btn_l, bus.btn_d, bus.btn_u};

  for (genvar i = 0; i < 5; i++) begin : g_edge
    edge_detect u_edge (
      .clk   (clk),
      .rst_n (rst_n),
      .level (btn_lvl[i]),
      .rise  (btn_rise[i])
    );
  end

  state_e           state_q, state_d;
  attack_e          atk_q, atk_d;
  logic [2:0]       step_q, step_d;
  logic [CNT_W-1:0] gap_q, gap_d;
  logic [CNT_W-1:0] hold_q, hold_d;
  logic [CNT_W-1:0] cool_q, cool_d;
  logic             from_cool_q, from_cool_d;

  logic       u_e, d_e, l_e, r_e, c_e;
  logic [3:0] dir_vec;
  logic       any_dir, multi_dir, match, complete;
  dir_e       exp_dir;

  always_comb begin
    u_e       = btn_rise[0];
    d_e       = btn_rise[1];
    l_e       = bus.mirrored ? btn_rise[3] : btn_rise[2];
    r_e       = bus.mirrored ? btn_rise[2] : btn_rise[3];
    c_e       = btn_rise[4];
    dir_vec   = {r_e, l_e, d_e, u_e};
    any_dir   = |dir_vec;
    multi_dir = (dir_vec & (dir_vec - 4'd1)) != 4'd0;
    exp_dir   = combo_dir(step_q);
    match     = any_dir && !multi_dir && dir_vec[exp_dir];
    complete  = match && (step_q == COMBO_LAST_STEP);
  end

  // Sequence matcher and inter-press gap timer.
  always_comb begin
    step_d = step_q;
    gap_d  = gap_q;
    if (any_dir) begin
      gap_d = '0;
      if (complete) begin
        step_d = '0;
      end else if (match) begin
        step_d = step_q + 3'd1;
      end else if (!multi_dir && u_e) begin
        // A stray U is itself a valid first press of a fresh attempt.
        step_d = 3'd1;
      end else begin
        step_d = '0;
      end
    end else if (bus.tick && (step_q != '0)) begin
      if (gap_q >= GAP_LAST) begin
        step_d = '0;
        gap_d  = '0;
      end else begin
        gap_d = gap_q + 1'b1;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    atk_d       = atk_q;
    hold_d      = hold_q;
    cool_d      = cool_q;
    from_cool_d = from_cool_q;
    case (state_q)
      ST_IDLE: begin
        if (complete) begin
          state_d = ST_SPECIAL;
          atk_d   = ATK_SPECIAL;
          hold_d  = '0;
        end else if (c_e) begin
          state_d     = ST_BASIC;
          atk_d       = ATK_BASIC;
          hold_d      = '0;
          from_cool_d = 1'b0;
        end
      end
      ST_BASIC: begin
        if (complete && !from_cool_q) begin
          state_d = ST_SPECIAL;
          atk_d   = ATK_SPECIAL;
          hold_d  = '0;
        end else if (bus.tick) begin
          if (hold_q >= HOLD_LAST) begin
            // A basic taken during cooldown resumes the frozen cooldown count.
            state_d     = from_cool_q ? ST_COOLDOWN : ST_IDLE;
            atk_d       = ATK_NONE;
            hold_d      = '0;
            from_cool_d = 1'b0;
          end else begin
            hold_d = hold_q + 1'b1;
          end
        end
      end
      ST_SPECIAL: begin
        if (bus.tick) begin
          if (hold_q >= HOLD_LAST) begin
            state_d = ST_COOLDOWN;
            atk_d   = ATK_NONE;
            hold_d  = '0;
            cool_d  = '0;
          end else begin
            hold_d = hold_q + 1'b1;
          end
        end
      end
      ST_COOLDOWN: begin
        if (c_e) begin
          state_d     = ST_BASIC;
          atk_d       = ATK_BASIC;
          hold_d      = '0;
          from_cool_d = 1'b1;
        end else if (bus.tick) begin
          if (cool_q >= COOL_LAST) begin
            state_d = ST_IDLE;
            cool_d  = '0;
          end else begin
            cool_d = cool_q + 1'b1;
          end
        end
      end
      default: begin
        state_d     = ST_IDLE;
        atk_d       = ATK_NONE;
        hold_d      = '0;
        cool_d      = '0;
        from_cool_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      atk_q       <= ATK_NONE;
      step_q      <= '0;
      gap_q       <= '0;
      hold_q      <= '0;
      cool_q      <= '0;
      from_cool_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      atk_q       <= atk_d;
      step_q      <= step_d;
      gap_q       <= gap_d;
      hold_q      <= hold_d;
      cool_q      <= cool_d;
      from_cool_q <= from_cool_d;
    end
  end

  assign bus.attack_state = atk_q;
  assign bus.combo_step   = step_q;

endmodule

// File: tb/tb_combo_detector.sv
// Directed-vector bench for combo_detector with default timing parameters.
module tb_combo_detector;
  import combo_detector_pkg::*;

  localparam logic [4:0] B_U = 5'b00001;
  localparam logic [4:0] B_D = 5'b00010;
  localparam logic [4:0] B_L = 5'b00100;
  localparam logic [4:0] B_R = 5'b01000;
  localparam logic [4:0] B_C = 5'b10000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int unsigned total = 0;
  int unsigned bad = 0;

  combo_detector_if bus ();

  combo_detector #(
    .COMBO_GAP_TICKS (500),
    .HOLD_TICKS      (50),
    .COOLDOWN_TICKS  (1000)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic set_btns(input logic [4:0] m);
    bus.btn_u = m[0];
    bus.btn_d = m[1];
    bus.btn_l = m[2];
    bus.btn_r = m[3];
    bus.btn_c = m[4];
  endtask

  task automatic press(input logic [4:0] m);
    @(negedge clk);
    set_btns(m);
    @(negedge clk);
    set_btns(5'b0);
    @(negedge clk);
  endtask

  task automatic ticks(input int unsigned n);
    repeat (n) begin
      @(negedge clk);
      bus.tick = 1'b1;
      @(negedge clk);
      bus.tick = 1'b0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    set_btns(5'b0);
    bus.tick     = 1'b0;
    bus.mirrored = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  // Six presses 20 ticks apart; the step is checked after each of the first five.
  task automatic run_combo(input string tag, input logic [4:0] s0, input logic [4:0] s1,
                           input logic [4:0] s2, input logic [4:0] s3,
                           input logic [4:0] s4, input logic [4:0] s5);
    logic [4:0] seq [6];
    seq = '{s0, s1, s2, s3, s4, s5};
    for (int i = 0; i < 6; i++) begin
      press(seq[i]);
      if (i < 5) begin
        check({tag, "_step"}, 32'(bus.combo_step), 32'(i + 1));
        ticks(20);
      end
    end
  endtask

  initial begin
    bus.tick     = 1'b0;
    bus.mirrored = 1'b0;
    set_btns(5'b0);
    repeat (3) @(negedge clk);
    check("rst_atk", 32'(bus.attack_state), 32'(ATK_NONE));
    check("rst_step", 32'(bus.combo_step), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Full combo, hold, then a second combo inside cooldown.
    run_combo("c1", B_U, B_D, B_L, B_R, B_L, B_R);
    check("c1_done_step", 32'(bus.combo_step), 32'd0);
    check("c1_special", 32'(bus.attack_state), 32'(ATK_SPECIAL));
    ticks(49);
    check("c1_hold49", 32'(bus.attack_state), 32'(ATK_SPECIAL));
    ticks(1);
    check("c1_hold50", 32'(bus.attack_state), 32'(ATK_NONE));
    run_combo("c2", B_U, B_D, B_L, B_R, B_L, B_R);
    check("cool_combo_step", 32'(bus.combo_step), 32'd0);
    check("cool_combo_atk", 32'(bus.attack_state), 32'(ATK_NONE));
    press(B_C);
    check("cool_basic", 32'(bus.attack_state), 32'(ATK_BASIC));
    ticks(50);
    check("cool_basic_end", 32'(bus.attack_state), 32'(ATK_NONE));
    ticks(900);
    run_combo("c3", B_U, B_D, B_L, B_R, B_L, B_R);
    check("after_cool_special", 32'(bus.attack_state), 32'(ATK_SPECIAL));

    // Mirrored mapping.
    do_reset();
    bus.mirrored = 1'b1;
    run_combo("mir", B_U, B_D, B_R, B_L, B_R, B_L);
    check("mir_special", 32'(bus.attack_state), 32'(ATK_SPECIAL));
    do_reset();
    press(B_U);
    press(B_D);
    press(B_R);
    check("unmir_wrong", 32'(bus.combo_step), 32'd0);

    // Gap timeout boundary.
    do_reset();
    press(B_U);
    ticks(20);
    press(B_D);
    ticks(499);
    check("gap_499", 32'(bus.combo_step), 32'd2);
    ticks(1);
    check("gap_500", 32'(bus.combo_step), 32'd0);
    ticks(1);
    press(B_L);
    check("gap_then_l", 32'(bus.combo_step), 32'd0);

    // Wrong U restarts at 1, btn_c leaves step alone, simultaneous directions reset.
    do_reset();
    press(B_U);
    press(B_D);
    press(B_U);
    check("wrong_u", 32'(bus.combo_step), 32'd1);
    press(B_D);
    check("step2", 32'(bus.combo_step), 32'd2);
    press(B_C);
    check("c_keeps_step", 32'(bus.combo_step), 32'd2);
    check("c_basic", 32'(bus.attack_state), 32'(ATK_BASIC));
    press(B_L | B_R);
    check("multi_dir", 32'(bus.combo_step), 32'd0);

    // Held btn_c gives one basic pulse; completion beats btn_c in the same clk.
    do_reset();
    @(negedge clk);
    bus.btn_c = 1'b1;
    @(negedge clk);
    check("held_c_basic", 32'(bus.attack_state), 32'(ATK_BASIC));
    ticks(49);
    check("held_c_49", 32'(bus.attack_state), 32'(ATK_BASIC));
    ticks(1);
    check("held_c_50", 32'(bus.attack_state), 32'(ATK_NONE));
    ticks(250);
    check("held_c_300", 32'(bus.attack_state), 32'(ATK_NONE));
    bus.btn_c = 1'b0;
    ticks(1);
    run_combo("cc", B_U, B_D, B_L, B_R, B_L, B_R | B_C);
    check("tie_special", 32'(bus.attack_state), 32'(ATK_SPECIAL));

    // Reset in the middle of a special, released with btn_u held.
    do_reset();
    run_combo("rs", B_U, B_D, B_L, B_R, B_L, B_R);
    ticks(10);
    check("rs_pre", 32'(bus.attack_state), 32'(ATK_SPECIAL));
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rs_async_atk", 32'(bus.attack_state), 32'(ATK_NONE));
    check("rs_async_step", 32'(bus.combo_step), 32'd0);
    bus.btn_u = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("rs_held_u", 32'(bus.combo_step), 32'd0);
    ticks(60);
    check("rs_no_residual", 32'(bus.attack_state), 32'(ATK_NONE));
    bus.btn_u = 1'b0;
    press(B_U);
    check("rs_fresh_u", 32'(bus.combo_step), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
